// File: rtl/clock_monitor_if.sv
// Signal bundle between the slow-clock source and the clock monitor:
// the monitored clock going in, tick/period/lock/loss status coming out.
interface clock_monitor_if #(
    parameter int WIDTH = 16
);
    logic             clk_in;
    logic             tick;
    logic [WIDTH-1:0] period;
    logic             locked;
    logic             lost;

    // Side that owns the slow clock and consumes the status.
    modport master (
        output clk_in,
        input  tick,
        input  period,
        input  locked,
        input  lost
    );

    // The monitor itself.
    modport slave (
        input  clk_in,
        output tick,
        output period,
        output locked,
        output lost
    );
endinterface

// File: rtl/clock_monitor.sv
// Clock monitor: synchronises an asynchronous slow clock into the system
// clock domain, emits a one-cycle tick per rising edge, measures the period
// between rises and tracks lock/loss of that clock against a nominal period.
module clock_monitor #(
    parameter int NOMINAL     = 100,
    parameter int TOLERANCE   = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 16
) (
    input  logic           clock,
    input  logic           reset,
    clock_monitor_if.slave mon
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH-1:0]  TIMEOUT_V = WIDTH'(2 * NOMINAL);
    localparam logic [WIDTH-1:0]  WIN_LO    = WIDTH'(NOMINAL - TOLERANCE);
    localparam logic [WIDTH-1:0]  WIN_HI    = WIDTH'(NOMINAL + TOLERANCE);
    localparam logic [GOOD_W-1:0] LOCK_V    = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [GOOD_W-1:0]       good, good_d;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    prev;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH-1:0]        meas;
    logic [WIDTH-1:0]        period_q;
    logic                    tick_q;
    logic                    sync_last;
    logic                    rise;
    logic                    in_win;
    logic                    timeout;
    logic                    period_valid;

    assign sync_last = sync[SYNC_STAGES-1];
    assign rise      = sync_last & ~prev;
    assign meas      = cnt + 1'b1;
    assign in_win    = (meas >= WIN_LO) && (meas <= WIN_HI);
    assign timeout   = !rise && (meas == TIMEOUT_V);

    // A rise out of IDLE or LOST has no trustworthy previous edge, so its
    // measurement is not published.
    assign period_valid = (state == S_ACQUIRE) || (state == S_LOCKED);

    // Synchroniser chain and previous-level register; reset high so a clock
    // already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], mon.clk_in};
            prev <= sync_last;
        end
    end

    // Cycles since the last rise, held at the timeout value once reached.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (cnt != TIMEOUT_V) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick pulse and published period, both registered from the rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q   <= 1'b0;
            period_q <= '0;
        end else begin
            tick_q <= rise;
            if (rise && period_valid) begin
                period_q <= meas;
            end
        end
    end

    // Lock-tracking state and good-period counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            good  <= '0;
        end else begin
            state <= state_d;
            good  <= good_d;
        end
    end

    // Next-state logic; a rise always takes priority over a timeout.
    always_comb begin
        state_d = state;
        good_d  = good;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_ACQUIRE;
                    good_d  = '0;
                end else if (timeout) begin
                    state_d = S_LOST;
                end
            end
            S_ACQUIRE: begin
                if (rise) begin
                    if (in_win) begin
                        good_d = good + 1'b1;
                        if (good + 1'b1 == LOCK_V) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = S_LOST;
                    good_d  = '0;
                end
            end
            S_LOCKED: begin
                if (rise && !in_win) begin
                    state_d = S_ACQUIRE;
                    good_d  = '0;
                end else if (timeout) begin
                    state_d = S_LOST;
                    good_d  = '0;
                end
            end
            S_LOST: begin
                if (rise) begin
                    state_d = S_ACQUIRE;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                good_d  = '0;
            end
        endcase
    end

    assign mon.tick   = tick_q;
    assign mon.period = period_q;
    assign mon.locked = (state == S_LOCKED);
    assign mon.lost   = (state == S_LOST);

endmodule
